// File: rtl/fsqrt_issue_if.sv
// Request/response handshake bundle between FPU dispatch, the fsqrt issue
// front end and the result consumer.
interface fsqrt_issue_if #(
    parameter int TAG_W = 4
);
    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_op;
    logic [TAG_W-1:0] req_tag;
    logic             resp_valid;
    logic             resp_ready;
    logic [31:0]      resp_result;
    logic [TAG_W-1:0] resp_tag;

    modport master (
        output req_valid, req_op, req_tag, resp_ready,
        input  req_ready, resp_valid, resp_result, resp_tag
    );

    modport slave (
        input  req_valid, req_op, req_tag, resp_ready,
        output req_ready, resp_valid, resp_result, resp_tag
    );
endinterface

// File: rtl/fsqrt_issue.sv
// Issue front end for the non-stallable pipelined fsqrt core: credit-gated
// request intake, fixed-latency tag tracking and a result FIFO for backpressure.
module fsqrt_issue #(
    parameter int LATENCY    = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 4
) (
    input  logic         clk,
    input  logic         reset,
    fsqrt_issue_if.slave bus,
    output logic [31:0]  sq_op,
    input  logic [31:0]  sq_result,
    output logic         busy
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] CREDITS = (CNT_W + 1)'(FIFO_DEPTH);

    logic [CNT_W-1:0]   inflight;
    logic [CNT_W-1:0]   fifo_count;
    logic [CNT_W:0]     committed;
    logic [LATENCY-1:0] pipe_valid;
    logic [TAG_W-1:0]   pipe_tag [LATENCY];
    logic [31:0]        fifo_result [FIFO_DEPTH];
    logic [TAG_W-1:0]   fifo_tag [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               accept;
    logic               push;
    logic               pop;

    // Every op in flight or buffered holds a FIFO slot, so capture can never overflow
    assign committed       = {1'b0, inflight} + {1'b0, fifo_count};
    assign bus.req_ready   = reset && (committed < CREDITS);
    assign accept          = bus.req_valid && bus.req_ready;
    assign push            = pipe_valid[LATENCY-1];
    assign pop             = bus.resp_valid && bus.resp_ready;
    assign bus.resp_valid  = (fifo_count != '0);
    assign bus.resp_result = fifo_result[rd_ptr];
    assign bus.resp_tag    = fifo_tag[rd_ptr];
    assign busy            = (inflight != '0) || (fifo_count != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sq_op <= '0;
        end else if (accept) begin
            sq_op <= bus.req_op;
        end
    end

    // Shadow of the core pipeline: free-running, bubbles shift in as invalid
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pipe_valid <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_tag[i] <= '0;
            end
        end else begin
            pipe_valid[0] <= accept;
            pipe_tag[0]   <= bus.req_tag;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_tag[i]   <= pipe_tag[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inflight   <= '0;
            fifo_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            inflight   <= inflight + CNT_W'(accept) - CNT_W'(push);
            fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_result[wr_ptr] <= sq_result;
            fifo_tag[wr_ptr]    <= pipe_tag[LATENCY-1];
        end
    end
endmodule

// File: tb/tb_fsqrt_issue.sv
// Scoreboard bench for fsqrt_issue: accepted requests queue their expected
// response, a negedge monitor pops and compares whatever the DUT returns.
module tb_fsqrt_issue;
    localparam int LATENCY    = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int TAG_W      = 4;
    localparam int SOAK_N     = 10000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] sq_op;
    logic [31:0] sq_result;
    logic        busy;
    logic [31:0] core_q;
    int          cycle = 0;

    int assert_count = 0;
    int fail_count   = 0;
    int accept_count = 0;

    logic [32+TAG_W-1:0] expected_q [$];
    int                  pop_cycles [$];

    fsqrt_issue_if #(.TAG_W(TAG_W)) bus ();

    fsqrt_issue #(
        .LATENCY(LATENCY),
        .FIFO_DEPTH(FIFO_DEPTH),
        .TAG_W(TAG_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave),
        .sq_op(sq_op),
        .sq_result(sq_result),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Stand-in for the fsqrt core: exact for the directed squares, a fixed
    // scramble otherwise so any corruption or reordering is still visible.
    function automatic logic [31:0] ref_sqrt(input logic [31:0] op);
        case (op)
            32'h3F80_0000: return 32'h3F80_0000;
            32'h4080_0000: return 32'h4000_0000;
            32'h4110_0000: return 32'h4040_0000;
            32'h4180_0000: return 32'h4080_0000;
            32'h0000_0000: return 32'h0000_0000;
            32'h8000_0000: return 32'h8000_0000;
            default:       return {op[31], op[30:0] ^ 31'h2A5A_5A5A};
        endcase
    endfunction

    // LATENCY-1 register stages after sq_op (LATENCY fixed at 2 here)
    always @(posedge clk) core_q <= ref_sqrt(sq_op);
    assign sq_result = core_q;

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] required);
        assert_count++;
        if (actual !== required) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, required, $time);
        end
    endtask

    always @(negedge clk) begin
        if (bus.req_valid && bus.req_ready) begin
            expected_q.push_back({ref_sqrt(bus.req_op), bus.req_tag});
            accept_count++;
        end
        if (dut.push) begin
            check_output("push_into_full_fifo", 64'(dut.fifo_count < FIFO_DEPTH), 64'd1);
        end
        if (bus.resp_valid && bus.resp_ready) begin
            pop_cycles.push_back(cycle);
            if (expected_q.size() == 0) begin
                assert_count++;
                fail_count++;
                $display("[TB] FAIL unexpected_response: got 0x%0h tag %0d, expected none",
                         bus.resp_result, bus.resp_tag);
            end else begin
                check_output("response", 64'({bus.resp_result, bus.resp_tag}),
                             64'(expected_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [31:0] op, input logic [TAG_W-1:0] tag,
                                  output int waits);
        logic fired;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_tag   = tag;
        waits         = 0;
        while (1) begin
            @(negedge clk);
            fired = bus.req_ready;
            tick();
            if (fired) break;
            waits++;
            if (waits >= 50) begin
                assert_count++;
                fail_count++;
                $display("[TB] FAIL issue_timeout: req_ready low for %0d cycles, expected high", waits);
                break;
            end
        end
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        check_output("drain_busy", 64'(busy), 64'd0);
        check_output("scoreboard_empty", 64'(expected_q.size()), 64'd0);
    endtask

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'h7FC0_0000;
            3:       return 32'h0000_0001;
            4:       return 32'hC080_0000;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        int waits;
        int n;
        int issued;
        int cyc;
        logic fire;
        logic [31:0] thru_ops [4];

        reset          = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_op     = '0;
        bus.req_tag    = '0;
        bus.resp_ready = 1'b0;
        #2 reset = 1'b0;

        // Reset state
        repeat (2) tick();
        @(negedge clk);
        check_output("rst_req_ready", 64'(bus.req_ready), 64'd0);
        check_output("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check_output("rst_busy", 64'(busy), 64'd0);
        check_output("rst_sq_op", 64'(sq_op), 64'd0);
        tick();
        reset = 1'b1;
        @(negedge clk);
        check_output("post_rst_req_ready", 64'(bus.req_ready), 64'd1);
        tick();

        $display("[TB] single op");
        bus.resp_ready = 1'b1;
        apply_stimulus(32'h4080_0000, 4'd3, waits);
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (bus.resp_valid) break;
        end
        check_output("single_latency", 64'(n), 64'(LATENCY + 1));
        tick();
        @(negedge clk);
        check_output("single_busy_after", 64'(busy), 64'd0);
        check_output("sq_op_hold", 64'(sq_op), 64'h4080_0000);
        tick();

        $display("[TB] throughput");
        thru_ops = '{32'h3F80_0000, 32'h4110_0000, 32'h4180_0000, 32'h0000_0000};
        pop_cycles.delete();
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(thru_ops[i], TAG_W'(i), waits);
            check_output("thru_no_stall", 64'(waits), 64'd0);
        end
        drain();
        check_output("thru_pop_count", 64'(pop_cycles.size()), 64'd4);
        if (pop_cycles.size() == 4) begin
            check_output("thru_consecutive", 64'(pop_cycles[3] - pop_cycles[0]), 64'd3);
        end

        $display("[TB] backpressure");
        bus.resp_ready = 1'b0;
        n = accept_count;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            apply_stimulus(32'h4000_0000 + 32'(i), TAG_W'(8 + i), waits);
        end
        bus.req_valid = 1'b1;
        bus.req_op    = 32'h4180_0000;
        bus.req_tag   = 4'd12;
        repeat (3) begin
            @(negedge clk);
            check_output("bp_stalled", 64'(bus.req_ready), 64'd0);
            tick();
        end
        check_output("bp_accept_count", 64'(accept_count - n), 64'(FIFO_DEPTH));
        bus.resp_ready = 1'b1;
        @(negedge clk);
        check_output("bp_ready_in_pop_cycle", 64'(bus.req_ready), 64'd0);
        tick();
        bus.resp_ready = 1'b0;
        @(negedge clk);
        check_output("bp_ready_after_pop", 64'(bus.req_ready), 64'd1);
        tick();
        bus.req_valid = 1'b0;
        drain();

        $display("[TB] simultaneous push/pop");
        bus.resp_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            apply_stimulus(rand_op(), TAG_W'(i), waits);
            check_output("stream_no_stall", 64'(waits), 64'd0);
            if (i >= 2) begin
                check_output("stream_fifo_count", 64'(dut.fifo_count), 64'd1);
            end
        end
        drain();

        $display("[TB] reset mid-flight");
        apply_stimulus(32'h3F80_0000, 4'd1, waits);
        apply_stimulus(32'h4110_0000, 4'd2, waits);
        reset = 1'b0;
        expected_q.delete();
        @(negedge clk);
        check_output("midrst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check_output("midrst_busy", 64'(busy), 64'd0);
        check_output("midrst_req_ready", 64'(bus.req_ready), 64'd0);
        repeat (2) tick();
        reset = 1'b1;
        @(negedge clk);
        check_output("midrst_release_ready", 64'(bus.req_ready), 64'd1);
        n = 0;
        repeat (8) begin
            tick();
            @(negedge clk);
            if (bus.resp_valid) n++;
        end
        check_output("midrst_no_stale", 64'(n), 64'd0);
        tick();

        $display("[TB] random soak");
        issued = 0;
        cyc    = 0;
        bus.req_valid = 1'b0;
        while (issued < SOAK_N && cyc < 60000) begin
            if (!bus.req_valid && $urandom_range(0, 3) != 0) begin
                bus.req_valid = 1'b1;
                bus.req_op    = rand_op();
                bus.req_tag   = TAG_W'(issued);
            end
            bus.resp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            fire = bus.req_valid && bus.req_ready;
            tick();
            cyc++;
            if (fire) begin
                issued++;
                bus.req_valid = 1'b0;
            end
        end
        check_output("soak_issued", 64'(issued), 64'(SOAK_N));
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end
endmodule
